// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller:
// opcode/funct constants, ALU op-select codes, mux selects, fault codes,
// controller states and the instruction classes produced by the decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_ORI = 3'b110;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  // ALU op-select codes, shared with the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NEQ = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_START, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB,
    ST_MEM_WRITE, ST_EXEC_R, ST_EXEC_I, ST_ALU_WB, ST_BRANCH, ST_ERROR
  } state_e;

  typedef enum logic [2:0] {
    CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_ITYPE, CLS_BRANCH, CLS_ILLEGAL
  } instr_cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies the instruction register
// contents, picks the R-type ALU op and flags unsupported encodings.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output instr_cls_e  cls,
  output logic [3:0]  r_alu_op,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // register and immediate fields only matter to the datapath
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Map opcode/funct fields to an instruction class and R-type ALU op
  always_comb begin
    cls      = CLS_ILLEGAL;
    r_alu_op = ALU_ADD;
    case (opcode)
      OPC_LOAD:   if (f3 == F3_LB) cls = CLS_LOAD;
      OPC_STORE:  if (f3 == F3_SB) cls = CLS_STORE;
      OPC_OPIMM:  if (f3 == F3_ORI) cls = CLS_ITYPE;
      OPC_BRANCH: if (f3 == F3_BNE) cls = CLS_BRANCH;
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD: begin cls = CLS_RTYPE; r_alu_op = ALU_ADD; end
            F3_AND: begin cls = CLS_RTYPE; r_alu_op = ALU_AND; end
            F3_SLL: begin cls = CLS_RTYPE; r_alu_op = ALU_SLL; end
            default: cls = CLS_ILLEGAL;
          endcase
        end
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the lb/sb/add/and/sll/ori/bne datapath.
// Outputs are Moore-decoded from the state register; FETCH write strobes
// are qualified by mem_ready and BRANCH pc_write follows ~zero.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int STALL_MAX = 16,
  parameter int ALU_OP_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                addr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic [1:0]          fault,
  output logic [31:0]         retired
);

  localparam int CNT_W = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;

  state_e           state_q, state_d;
  logic [1:0]       fault_q, fault_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  instr_cls_e       cls;
  logic [3:0]       r_alu_op;
  logic             illegal;
  logic             waiting;
  logic             stall_limit;
  logic             retire_evt;
  logic [3:0]       alu_op_int;

  ctrl_decode u_decode (
    .instr    (instr),
    .cls      (cls),
    .r_alu_op (r_alu_op),
    .illegal  (illegal)
  );

  assign waiting     = (state_q inside {ST_FETCH, ST_MEM_READ, ST_MEM_WRITE}) && !mem_ready;
  // the limit cycle is the STALL_MAX-th consecutive wait; a ready in it still wins
  assign stall_limit = (STALL_MAX != 0) && ((int'(stall_q) + 1) == STALL_MAX);

  // Next-state, fault and retire-event logic
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    retire_evt = 1'b0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)        state_d = ST_DECODE;
        else if (stall_limit) begin state_d = ST_ERROR; fault_d = FAULT_TIMEOUT; end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_d = ST_ERROR;
          fault_d = FAULT_ILLEGAL;
        end else begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = ST_MEM_ADDR;
            CLS_RTYPE:           state_d = ST_EXEC_R;
            CLS_ITYPE:           state_d = ST_EXEC_I;
            CLS_BRANCH:          state_d = ST_BRANCH;
            default: begin state_d = ST_ERROR; fault_d = FAULT_ILLEGAL; end
          endcase
        end
      end
      ST_MEM_ADDR: state_d = (cls == CLS_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: begin
        if (mem_ready)        state_d = ST_MEM_WB;
        else if (stall_limit) begin state_d = ST_ERROR; fault_d = FAULT_TIMEOUT; end
      end
      ST_MEM_WB: begin state_d = ST_FETCH; retire_evt = 1'b1; end
      ST_MEM_WRITE: begin
        if (mem_ready)        begin state_d = ST_FETCH; retire_evt = 1'b1; end
        else if (stall_limit) begin state_d = ST_ERROR; fault_d = FAULT_TIMEOUT; end
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
      ST_ALU_WB: begin state_d = ST_FETCH; retire_evt = 1'b1; end
      ST_BRANCH: begin state_d = ST_FETCH; retire_evt = 1'b1; end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_START;
    endcase

    if ((state_d != state_q) || mem_ready) stall_d = '0;
    else if (waiting)                      stall_d = stall_q + CNT_W'(1);
    else                                   stall_d = stall_q;
  end

  // State, fault and stall-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
      fault_q <= FAULT_NONE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      stall_q <= stall_d;
    end
  end

  // Datapath strobes and mux selects decoded from the current state
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op_int = 4'b0000;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      ST_START: alu_op_int = ALU_ADD;
      ST_FETCH: begin
        mem_read   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op_int = ALU_ADD;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      ST_DECODE: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        alu_op_int = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op_int = ALU_ADD;
      end
      ST_MEM_READ:  begin mem_read  = 1'b1; addr_src = 1'b1; end
      ST_MEM_WB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      ST_MEM_WRITE: begin mem_write = 1'b1; addr_src = 1'b1; end
      ST_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op_int = r_alu_op;
      end
      ST_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op_int = ALU_OR;
      end
      ST_ALU_WB: reg_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op_int = ALU_NEQ;
        pc_src     = 1'b1;
        pc_write   = ~zero;
      end
      default: ;
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_op_int);
  assign fault  = fault_q;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Count completed instructions; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset)           retired_q <= '0;
    else if (retire_evt) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire_evt;
  assign retired       = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues per-cycle
// stimulus with the expected output vector, then replays and compares.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_read, mem_write, addr_src, ir_write, pc_write, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, fault;
  logic [3:0]  alu_op;
  logic        reg_write, mem_to_reg;
  logic [31:0] retired;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  localparam int S_START = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3, S_MREAD = 4,
                 S_MWB = 5, S_MWRITE = 6, S_EXR = 7, S_EXI = 8, S_AWB = 9,
                 S_BR = 10, S_ERRI = 11, S_ERRT = 12;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_AND = 32'h0020F1B3;
  localparam logic [31:0] I_SLL = 32'h002091B3;
  localparam logic [31:0] I_ORI = 32'h0050E093;
  localparam logic [31:0] I_BNE = 32'h00209463;
  localparam logic [31:0] I_LB  = 32'h00008283;
  localparam logic [31:0] I_SB  = 32'h00208223;
  localparam logic [31:0] I_ILL = 32'h0000007F;

  typedef struct {
    logic        rdy;
    logic        zr;
    logic [31:0] ins;
    logic [17:0] exp;
  } step_t;

  step_t sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.STALL_MAX(4), .ALU_OP_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr_src(addr_src),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .fault(fault), .retired(retired)
  );

  assign obs = {mem_read, mem_write, addr_src, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, fault};

  // Expected output vector for a state, from the controller's output table
  function automatic logic [17:0] ev(input int st, input logic rdy, input logic zr,
                                     input logic [3:0] op);
    logic mr, mw, asrc, irw, pcw, pcs, rw, m2r;
    logic [1:0] a, b, f;
    logic [3:0] o;
    {mr, mw, asrc, irw, pcw, pcs, rw, m2r} = '0;
    a = 2'b00; b = 2'b00; f = 2'b00; o = 4'b0000;
    case (st)
      S_START:  o = 4'b0010;
      S_FETCH:  begin mr = 1; b = 2'b01; o = 4'b0010; irw = rdy; pcw = rdy; end
      S_DECODE: begin a = 2'b10; b = 2'b10; o = 4'b0010; end
      S_MADDR:  begin a = 2'b01; b = 2'b10; o = 4'b0010; end
      S_MREAD:  begin mr = 1; asrc = 1; end
      S_MWB:    begin rw = 1; m2r = 1; end
      S_MWRITE: begin mw = 1; asrc = 1; end
      S_EXR:    begin a = 2'b01; b = 2'b00; o = op; end
      S_EXI:    begin a = 2'b01; b = 2'b10; o = 4'b0001; end
      S_AWB:    rw = 1;
      S_BR:     begin a = 2'b01; b = 2'b00; o = 4'b0110; pcs = 1; pcw = ~zr; end
      S_ERRI:   f = 2'b01;
      S_ERRT:   f = 2'b10;
      default:  ;
    endcase
    return {mr, mw, asrc, irw, pcw, pcs, a, b, o, rw, m2r, f};
  endfunction

  function automatic void push(input int st, input logic rdy, input logic zr,
                               input logic [31:0] ins, input logic [3:0] op);
    step_t s;
    s.rdy = rdy; s.zr = zr; s.ins = ins; s.exp = ev(st, rdy, zr, op);
    sb.push_back(s);
  endfunction

  // Leaves the bench at posedge+1 of the START cycle
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; instr = I_ADD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (obs !== ev(S_START, 0, 0, 0)) begin
      errors++; $display("FAIL reset_outputs got %h want %h", obs, ev(S_START, 0, 0, 0));
    end
    checks++;
    if (retired !== 32'd0) begin
      errors++; $display("FAIL reset_retired got %0d want 0", retired);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_add();
    int n = 0;
    step_t s;
    do_reset();
    push(S_START, 1, 0, I_ADD, 0);
    push(S_FETCH, 1, 0, I_ADD, 0);
    push(S_DECODE, 1, 0, I_ADD, 0);
    push(S_EXR, 1, 0, I_ADD, 4'b0010);
    push(S_AWB, 1, 0, I_ADD, 0);
    push(S_FETCH, 1, 0, I_ADD, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL add step %0d got %h want %h", n, obs, s.exp);
      end
      if (n == 5) begin
        checks++;
        if (retired !== (RET_EN ? 32'd1 : 32'd0)) begin
          errors++; $display("FAIL add_retired got %0d want %0d", retired, RET_EN ? 1 : 0);
        end
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    int n = 0;
    step_t s;
    do_reset();
    push(S_START, 1, 0, I_AND, 0);
    push(S_FETCH, 1, 0, I_AND, 0);
    push(S_DECODE, 1, 0, I_AND, 0);
    push(S_EXR, 1, 0, I_AND, 4'b0000);
    push(S_AWB, 1, 0, I_AND, 0);
    push(S_FETCH, 1, 0, I_SLL, 0);
    push(S_DECODE, 1, 0, I_SLL, 0);
    push(S_EXR, 1, 0, I_SLL, 4'b1000);
    push(S_AWB, 1, 0, I_SLL, 0);
    push(S_FETCH, 1, 0, I_ORI, 0);
    push(S_DECODE, 1, 0, I_ORI, 0);
    push(S_EXI, 1, 0, I_ORI, 0);
    push(S_AWB, 1, 0, I_ORI, 0);
    push(S_FETCH, 1, 0, I_ORI, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL alu_ops step %0d got %h want %h", n, obs, s.exp);
      end
      n++;
      if (sb.size() == 0) begin
        checks++;
        if (retired !== (RET_EN ? 32'd3 : 32'd0)) begin
          errors++; $display("FAIL alu_ops_retired got %0d want %0d", retired, RET_EN ? 3 : 0);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bne();
    int n = 0;
    step_t s;
    do_reset();
    push(S_START, 1, 0, I_BNE, 0);
    push(S_FETCH, 1, 0, I_BNE, 0);
    push(S_DECODE, 1, 0, I_BNE, 0);
    push(S_BR, 1, 0, I_BNE, 0);
    push(S_FETCH, 1, 1, I_BNE, 0);
    push(S_DECODE, 1, 1, I_BNE, 0);
    push(S_BR, 1, 1, I_BNE, 0);
    push(S_FETCH, 1, 0, I_BNE, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL bne step %0d got %h want %h", n, obs, s.exp);
      end
      n++;
      if (sb.size() == 0) begin
        checks++;
        if (retired !== (RET_EN ? 32'd2 : 32'd0)) begin
          errors++; $display("FAIL bne_retired got %0d want %0d", retired, RET_EN ? 2 : 0);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lb_wait();
    int n = 0;
    step_t s;
    do_reset();
    push(S_START, 1, 0, I_LB, 0);
    push(S_FETCH, 1, 0, I_LB, 0);
    push(S_DECODE, 1, 0, I_LB, 0);
    push(S_MADDR, 1, 0, I_LB, 0);
    for (int i = 0; i < 3; i++) push(S_MREAD, 0, 0, I_LB, 0);
    push(S_MREAD, 1, 0, I_LB, 0);
    push(S_MWB, 1, 0, I_LB, 0);
    push(S_FETCH, 1, 0, I_LB, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL lb_wait step %0d got %h want %h", n, obs, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int n = 0;
    step_t s;
    do_reset();
    push(S_START, 1, 0, I_ILL, 0);
    push(S_FETCH, 1, 0, I_ILL, 0);
    push(S_DECODE, 1, 0, I_ILL, 0);
    for (int i = 0; i < 12; i++) push(S_ERRI, i[0], i[1], I_ILL, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL illegal step %0d got %h want %h", n, obs, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ev(S_START, 0, 0, 0)) begin
      errors++; $display("FAIL illegal_reset got %h want %h", obs, ev(S_START, 0, 0, 0));
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    step_t s;
    do_reset();
    push(S_START, 0, 0, I_ADD, 0);
    for (int i = 0; i < 4; i++) push(S_FETCH, 0, 0, I_ADD, 0);
    for (int i = 0; i < 3; i++) push(S_ERRT, 0, 0, I_ADD, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL timeout step %0d got %h want %h", n, obs, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    n = 0;
    do_reset();
    push(S_START, 0, 0, I_ADD, 0);
    for (int i = 0; i < 3; i++) push(S_FETCH, 0, 0, I_ADD, 0);
    push(S_FETCH, 1, 0, I_ADD, 0);
    push(S_DECODE, 1, 0, I_ADD, 0);
    push(S_EXR, 1, 0, I_ADD, 4'b0010);
    push(S_AWB, 1, 0, I_ADD, 0);
    push(S_FETCH, 1, 0, I_ADD, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL limit_ready step %0d got %h want %h", n, obs, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    step_t s;
    do_reset();
    push(S_START, 1, 0, I_SB, 0);
    push(S_FETCH, 1, 0, I_SB, 0);
    push(S_DECODE, 1, 0, I_SB, 0);
    push(S_MADDR, 1, 0, I_SB, 0);
    push(S_MWRITE, 1, 0, I_SB, 0);
    push(S_FETCH, 1, 0, I_SB, 0);
    push(S_DECODE, 1, 0, I_SB, 0);
    push(S_MADDR, 1, 0, I_SB, 0);
    push(S_MWRITE, 0, 0, I_SB, 0);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zr; instr = s.ins;
      @(negedge clk);
      checks++;
      if (obs !== s.exp) begin
        errors++; $display("FAIL sb step %0d got %h want %h", n, obs, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (retired !== (RET_EN ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL sb_retired got %0d want %0d", retired, RET_EN ? 1 : 0);
    end
    // still in MEM_WRITE: reset wins even though memory reports ready
    #1 reset = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ev(S_START, 0, 0, 0)) begin
      errors++; $display("FAIL abort_outputs got %h want %h", obs, ev(S_START, 0, 0, 0));
    end
    checks++;
    if (retired !== 32'd0) begin
      errors++; $display("FAIL abort_retired got %0d want 0", retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b1; instr = 32'd0;
    test_reset();
    test_add();
    test_alu_ops();
    test_bne();
    test_lb_wait();
    test_illegal();
    test_timeout();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
